// File: rtl/hazard_stall_ctrl.sv
// Front-end hazard controller: load-use stalls, multi-cycle multiply stalls,
// branch flushes of IF/ID and a saturating stall-cycle counter.
module hazard_stall_ctrl #(
  parameter int MULT_LAT = 4,
  parameter int CNT_W    = 16
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic [4:0]       ID_Rs,
  input  logic [4:0]       ID_Rt,
  input  logic             ID_UsesRt,
  input  logic             ID_IsMult,
  input  logic             EX_MemRead,
  input  logic [4:0]       EX_Rt,
  input  logic             BranchTaken,
  output logic             PC_En,
  output logic             IFID_En,
  output logic             IFID_Flush,
  output logic             IDEX_Bubble,
  output logic [CNT_W-1:0] StallCount
);

  localparam logic [0:0] RUN      = 1'b0;
  localparam logic [0:0] MULSTALL = 1'b1;

  // The issue cycle is not a stall, so the counter starts two below the latency.
  localparam logic [4:0] CNT_LOAD = (MULT_LAT > 1) ? 5'(MULT_LAT - 2) : 5'd0;

  logic [0:0]       state_q, state_d;
  logic [4:0]       cnt_q, cnt_d;
  logic             pend_flush_q, pend_flush_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;

  logic load_use;
  logic pc_en, ifid_en, ifid_flush, idex_bubble;

  assign load_use = EX_MemRead && (EX_Rt != 5'd0) &&
                    ((EX_Rt == ID_Rs) || (ID_UsesRt && (EX_Rt == ID_Rt)));

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pend_flush_d = pend_flush_q;
    pc_en        = 1'b1;
    ifid_en      = 1'b1;
    ifid_flush   = 1'b0;
    idex_bubble  = 1'b0;
    case (state_q)
      RUN: begin
        if (BranchTaken || pend_flush_q) begin
          ifid_flush   = 1'b1;
          pend_flush_d = 1'b0;
        end else if (ID_IsMult && (MULT_LAT > 1)) begin
          cnt_d   = CNT_LOAD;
          state_d = MULSTALL;
        end else if (load_use) begin
          pc_en       = 1'b0;
          ifid_en     = 1'b0;
          idex_bubble = 1'b1;
        end
      end
      MULSTALL: begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_bubble = 1'b1;
        // A branch resolved under the stall is remembered and flushed on return to RUN.
        if (BranchTaken) pend_flush_d = 1'b1;
        if (cnt_q == 5'd0) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = 5'd0;
      end
    endcase
  end

  always_comb begin
    stall_count_d = stall_count_q;
    if (!pc_en && (stall_count_q != {CNT_W{1'b1}})) begin
      stall_count_d = stall_count_q + CNT_W'(1);
    end
  end

  assign PC_En       = Rst_n & pc_en;
  assign IFID_En     = Rst_n & ifid_en;
  assign IFID_Flush  = Rst_n & ifid_flush;
  assign IDEX_Bubble = ~Rst_n | idex_bubble;
  assign StallCount  = stall_count_q;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q       <= RUN;
      cnt_q         <= 5'd0;
      pend_flush_q  <= 1'b0;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      pend_flush_q  <= pend_flush_d;
      stall_count_q <= stall_count_d;
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: directed scenarios followed by
// random traffic, all compared against a cycle-level behavioural model.
module tb_hazard_stall_ctrl;

  localparam int MULT_LAT = 4;
  localparam int CNT_W    = 6;
  localparam int MAX_CNT  = (1 << CNT_W) - 1;

  logic             Clk = 1'b0;
  logic             Rst_n;
  logic [4:0]       ID_Rs, ID_Rt, EX_Rt;
  logic             ID_UsesRt, ID_IsMult, EX_MemRead, BranchTaken;
  logic             PC_En, IFID_En, IFID_Flush, IDEX_Bubble;
  logic [CNT_W-1:0] StallCount;

  int errorCount = 0;
  int checkCount = 0;

  // Model state: remaining multiply stall cycles, deferred flush, stall count.
  int mulLeft  = 0;
  bit pendMod  = 0;
  int cntMod   = 0;

  hazard_stall_ctrl #(.MULT_LAT(MULT_LAT), .CNT_W(CNT_W)) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRt(ID_UsesRt), .ID_IsMult(ID_IsMult),
    .EX_MemRead(EX_MemRead), .EX_Rt(EX_Rt), .BranchTaken(BranchTaken),
    .PC_En(PC_En), .IFID_En(IFID_En), .IFID_Flush(IFID_Flush),
    .IDEX_Bubble(IDEX_Bubble), .StallCount(StallCount)
  );

  always #5 Clk = ~Clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // One clock cycle: drive inputs at negedge, check outputs, then check the count after posedge.
  task automatic applyStimulus(input bit rstn, input int rs, input int rt, input bit usesRt,
                               input bit isMult, input bit memRead, input int exRt,
                               input bit branch);
    bit expPc, expIfid, expFlush, expBubble, lu;
    @(negedge Clk);
    Rst_n       = rstn;
    ID_Rs       = 5'(rs);
    ID_Rt       = 5'(rt);
    ID_UsesRt   = usesRt;
    ID_IsMult   = isMult;
    EX_MemRead  = memRead;
    EX_Rt       = 5'(exRt);
    BranchTaken = branch;
    #1;
    if (!rstn) begin
      mulLeft = 0;
      pendMod = 0;
      cntMod  = 0;
    end
    lu = memRead && exRt != 0 && (exRt == rs || (usesRt && exRt == rt));
    expPc = 1; expIfid = 1; expFlush = 0; expBubble = 0;
    if (!rstn) begin
      expPc = 0; expIfid = 0; expBubble = 1;
    end else if (mulLeft > 0) begin
      expPc = 0; expIfid = 0; expBubble = 1;
    end else if (branch || pendMod) begin
      expFlush = 1;
    end else if (!(isMult && MULT_LAT > 1) && lu) begin
      expPc = 0; expIfid = 0; expBubble = 1;
    end
    checkOutput("PC_En", 32'(PC_En), 32'(expPc));
    checkOutput("IFID_En", 32'(IFID_En), 32'(expIfid));
    checkOutput("IFID_Flush", 32'(IFID_Flush), 32'(expFlush));
    checkOutput("IDEX_Bubble", 32'(IDEX_Bubble), 32'(expBubble));
    @(posedge Clk);
    #1;
    if (rstn) begin
      if (!expPc && cntMod < MAX_CNT) cntMod++;
      if (mulLeft > 0) begin
        if (branch) pendMod = 1;
        mulLeft--;
      end else if (branch || pendMod) begin
        pendMod = 0;
      end else if (isMult && MULT_LAT > 1) begin
        mulLeft = MULT_LAT - 1;
      end
    end
    checkOutput("StallCount", 32'(StallCount), 32'(cntMod));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    Rst_n = 0; ID_Rs = 0; ID_Rt = 0; ID_UsesRt = 0; ID_IsMult = 0;
    EX_MemRead = 0; EX_Rt = 0; BranchTaken = 0;

    // Reset state and plain running.
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("reset_count", 32'(StallCount), 32'd0);
    idle(10);
    checkOutput("run_count", 32'(StallCount), 32'd0);

    // Load-use on rs stalls exactly one cycle.
    applyStimulus(1, 8, 0, 0, 0, 1, 8, 0);
    idle(2);
    checkOutput("lu_count", 32'(StallCount), 32'd1);

    // No stall for r0 or an rt match when rt is not a source.
    applyStimulus(1, 0, 0, 1, 0, 1, 0, 0);
    applyStimulus(1, 3, 9, 0, 0, 1, 9, 0);
    applyStimulus(1, 3, 9, 1, 0, 1, 9, 0);
    checkOutput("lu_rt_count", 32'(StallCount), 32'd2);

    // Multiply: issue cycle then MULT_LAT-1 stall cycles.
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 1, 0, 0, 0);
    idle(5);
    checkOutput("mul_count", 32'(StallCount), 32'(MULT_LAT - 1));

    // Branch in the second stall cycle is deferred to the first RUN cycle.
    applyStimulus(1, 0, 0, 0, 1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 1);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    idle(2);

    // Branch beats a simultaneous load-use and multiply.
    applyStimulus(1, 5, 0, 0, 1, 1, 5, 1);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);

    // Reset in the middle of a multiply stall drops the pending flush.
    applyStimulus(1, 0, 0, 0, 1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("midreset_count", 32'(StallCount), 32'd0);
    idle(3);

    // Saturation of the stall counter.
    for (int i = 0; i < 25; i++) begin
      applyStimulus(1, 0, 0, 0, 1, 0, 0, 0);
      idle(3);
    end
    checkOutput("sat_count", 32'(StallCount), 32'(MAX_CNT));

    // Random traffic with small register numbers so hazards are frequent.
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 500; i++) begin
      applyStimulus(($urandom_range(0, 63) != 0),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
                    1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                    ($urandom_range(0, 7) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
